// File: rtl/fir_tap_line.sv
// Parametrised tap delay line with valid/ready on both sides, flush and fill counter.
// Optional build macro TAPLINE_PRIME_EN: hold off out_valid until all TAPS taps hold real samples.

module fir_tap_line_chk #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 8,
  parameter int CNT_W  = 4
) (
  input logic                     clk,
  input logic                     rst,
  input logic                     flush,
  input logic                     in_ready,
  input logic                     out_valid,
  input logic                     out_ready,
  input logic [TAPS*DATA_W-1:0]   taps_out,
  input logic [CNT_W-1:0]         fill_count
);

  // A stalled snapshot must not move until downstream takes it.
  hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> $stable(taps_out));

  fill_bound: assert property (@(posedge clk) disable iff (rst)
    fill_count <= CNT_W'(TAPS));

  stall_blocks_input: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |-> !in_ready);

endmodule

module fir_tap_line #(
  parameter int DATA_W = 16,
  parameter int TAPS   = 8,
  parameter int CNT_W  = $clog2(TAPS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAPS*DATA_W-1:0] taps_out,
  output logic [CNT_W-1:0]       fill_count
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(TAPS);

  logic [TAPS*DATA_W-1:0] taps_r;
  logic                   valid_r;
  logic [CNT_W-1:0]       fill_r;

  logic                   accept_s;
  logic                   consume_s;
  logic                   sets_valid_s;
  logic [CNT_W-1:0]       fill_nxt_s;

  assign in_ready = (!valid_r || out_ready) && !flush;

  // Handshake decode and saturating fill count.
  always_comb begin
    accept_s  = in_valid && in_ready;
    consume_s = valid_r && out_ready;
    if (fill_r == FULL) begin
      fill_nxt_s = fill_r;
    end else begin
      fill_nxt_s = fill_r + CNT_W'(1);
    end
`ifdef TAPLINE_PRIME_EN
    sets_valid_s = accept_s && (fill_nxt_s == FULL);
`else
    sets_valid_s = accept_s;
`endif
  end

  // Tap history, snapshot flag and fill counter; flush outranks accept and consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_r  <= '0;
      valid_r <= 1'b0;
      fill_r  <= '0;
    end else if (flush) begin
      taps_r  <= '0;
      valid_r <= 1'b0;
      fill_r  <= '0;
    end else begin
      if (accept_s) begin
        taps_r <= {taps_r[(TAPS-1)*DATA_W-1:0], data_in};
        fill_r <= fill_nxt_s;
      end
      if (sets_valid_s) begin
        valid_r <= 1'b1;
      end else if (consume_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign taps_out   = taps_r;
  assign out_valid  = valid_r;
  assign fill_count = fill_r;

  fir_tap_line_chk #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS),
    .CNT_W  (CNT_W)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .taps_out   (taps_out),
    .fill_count (fill_count)
  );

endmodule
